// File: rtl/mux_nx1_hs.sv
// N-channel registered mux with valid/ready handshakes.
// Select mode uses sel directly; round-robin mode rotates fairly over requesters.
module mux_nx1_hs #(
  parameter  int DATA_W = 16,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [SEL_W:0]   NCH_L  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_CH - 1);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              can_load;
  logic              grant_ok;
  logic [SEL_W-1:0]  gnt;
  logic [SEL_W-1:0]  cand;
  logic [DATA_W-1:0] gnt_data;
  logic              accept;

  // Grant: direct select, or first requester after rr_ptr with wrap.
  always_comb begin
    gnt      = '0;
    grant_ok = 1'b0;
    cand     = '0;
    if (!mode) begin
      gnt      = sel;
      grant_ok = ({1'b0, sel} < NCH_L);
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        cand = SEL_W'((int'(rr_ptr_q) + k) % N_CH);
        if (!grant_ok && in_valid[cand]) begin
          gnt      = cand;
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Handshake: one ready bit at most, only when the slot can take a word.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = can_load && grant_ok && (gnt == SEL_W'(i));
      if (gnt == SEL_W'(i)) begin
        gnt_data = in_data[i*DATA_W +: DATA_W];
      end
    end
    accept = |(in_valid & in_ready);
  end

  // Next state of the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = gnt;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any buffered word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= PTR_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_hs.sv
// Bench for mux_nx1_hs: cycle model check on a 4-channel instance,
// plus directed literal checks, and a 3-channel instance for illegal select.
module tb_mux_nx1_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_nx1_hs #(.DATA_W(16), .N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_nx1_hs #(.DATA_W(16), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model of the 4-channel instance
  int          m_rr;
  bit          m_v;
  logic [15:0] m_d;
  int          m_ch;

  function automatic int grant_of();
    if (mode == 1'b0) return int'(sel);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_rr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr = 3;
      m_v  = 0;
      m_d  = 16'h0;
      m_ch = 0;
    end else begin
      int g;
      g = grant_of();
      if ((!m_v || out_ready) && g >= 0 && in_valid[g]) begin
        m_d  = in_data[g*16 +: 16];
        m_ch = g;
        m_v  = 1;
        if (mode) m_rr = g;
      end else if (out_ready) begin
        m_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      int g;
      logic [3:0] er;
      g  = grant_of();
      er = ((!m_v || out_ready) && g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("model_in_ready", 64'(in_ready), 64'(er));
      chk("model_out_valid", 64'(out_valid), 64'(m_v));
      chk("model_out_data", 64'(out_data), 64'(m_d));
      chk("model_out_ch", 64'(out_ch), 64'(m_ch));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 64'h0;
    in_valid  = 4'h0;
    out_ready = 1'b1;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_data3   = 48'h0;
    in_valid3  = 3'h0;
    out_ready3 = 1'b1;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    #10;
    rst_n = 1'b1;

    // Round-robin fairness from reset
    cyc();
    mode     = 1'b1;
    in_data  = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_ch", 64'(out_ch), 64'(i % 4));
      chk("rr_data", 64'(out_data), 64'(i % 4));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end

    // External select
    mode    = 1'b0;
    sel     = 2'd2;
    in_data = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    #1;
    chk("sel_in_ready", 64'(in_ready), 64'b0100);
    cyc();
    chk("sel_data", 64'(out_data), 64'hBEEF);
    chk("sel_ch", 64'(out_ch), 64'd2);
    chk("sel_valid", 64'(out_valid), 64'd1);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    sel       = 2'd1;
    in_data   = {16'h3333, 16'h2222, 16'hCAFE, 16'h0000};
    #1;
    chk("bp_in_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_data", 64'(out_data), 64'hBEEF);
      chk("bp_ch", 64'(out_ch), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 64'(in_ready), 64'b0010);
    cyc();
    chk("drain_data", 64'(out_data), 64'hCAFE);
    chk("drain_ch", 64'(out_ch), 64'd1);
    chk("drain_valid", 64'(out_valid), 64'd1);
    in_valid = 4'h0;
    cyc();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_hold", 64'(out_data), 64'hCAFE);

    // Sparse round-robin: set rr_ptr=1 via a lone ch1 grant
    mode     = 1'b1;
    in_data  = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
    in_valid = 4'b0010;
    cyc();
    chk("sp_setup_ch", 64'(out_ch), 64'd1);
    in_valid = 4'b1010;
    cyc();
    chk("sp_ch3a", 64'(out_ch), 64'd3);
    chk("sp_d3a", 64'(out_data), 64'h0033);
    cyc();
    chk("sp_ch1", 64'(out_ch), 64'd1);
    chk("sp_d1", 64'(out_data), 64'h0011);
    cyc();
    chk("sp_ch3b", 64'(out_ch), 64'd3);
    in_valid = 4'h0;
    cyc();

    // Illegal select on the 3-channel instance
    sel3      = 2'd1;
    in_data3  = {16'h0C02, 16'h0C01, 16'h0C00};
    in_valid3 = 3'b111;
    cyc();
    chk("n3_ch", 64'(out_ch3), 64'd1);
    chk("n3_valid", 64'(out_valid3), 64'd1);
    sel3 = 2'd3;
    #1;
    chk("n3_illegal_rdy", 64'(in_ready3), 64'd0);
    cyc();
    chk("n3_drained", 64'(out_valid3), 64'd0);
    chk("n3_hold", 64'(out_data3), 64'h0C01);

    // Async reset mid-cycle while holding a word
    in_valid = 4'hF;
    cyc();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_ch", 64'(out_ch), 64'd0);
    #10;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ch0", 64'(out_ch), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    in_valid = 4'h0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
